// File: rtl/ntt_pkg.sv
// Shared NTT front-end constants: default frame geometry, modulus, step width
// and the loader FSM encoding.
package ntt_pkg;
   localparam int NTT_WIDTH   = 32;
   localparam int NTT_SIZE    = 257;
   localparam int NTT_MODULUS = 1543;
   localparam int STEP_W      = 3;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } ld_state_t;

   // Index counter width; a one-slot frame still needs a 1-bit counter.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/coef_cond_sub.sv
// Combinational single conditional subtraction: maps [0, 2*MODULUS) into [0, MODULUS).
module coef_cond_sub #(
   parameter int WIDTH   = 32,
   parameter int MODULUS = 1543
) (
   input  logic [WIDTH-1:0] coef,
   output logic [WIDTH-1:0] reduced
);
   localparam logic [WIDTH-1:0] MOD = WIDTH'(MODULUS);

   assign reduced = (coef >= MOD) ? coef - MOD : coef;
endmodule

// File: rtl/coef_frame_loader.sv
// Streams SIZE coefficients into a parallel frame for the bit-reversal stage.
// Define COEF_FRAME_LOADER_REDUCE_EN to reduce each coefficient by MODULUS on entry.
module coef_frame_loader
   import ntt_pkg::*;
#(
   parameter int WIDTH   = NTT_WIDTH,
   parameter int SIZE    = NTT_SIZE,
   parameter int MODULUS = NTT_MODULUS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      in_coef,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [STEP_W-1:0]     in_step,
   output logic [SIZE*WIDTH-1:0] out_list,
   output logic [STEP_W-1:0]     out_step,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  err_len
);
   localparam int              IDX_W    = idx_bits(SIZE);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

   if (MODULUS < 2 || $clog2(MODULUS + 1) > WIDTH) begin : g_bad_modulus
      $error("coef_frame_loader: MODULUS must be >= 2 and fit in WIDTH bits");
   end

   ld_state_t        state, state_nxt;
   logic             live;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] coef_w;
   logic [WIDTH-1:0] slot [SIZE];
   logic             accept, at_last, frame_bad;

`ifdef COEF_FRAME_LOADER_REDUCE_EN
   coef_cond_sub #(
      .WIDTH  (WIDTH),
      .MODULUS(MODULUS)
   ) u_cond_sub (
      .coef   (in_coef),
      .reduced(coef_w)
   );
`else
   assign coef_w = in_coef;
`endif

   assign at_last   = (idx == IDX_LAST);
   assign accept    = in_valid && in_ready;
   assign frame_bad = accept && (in_last != at_last);

   // live keeps in_ready low during reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FILL;
         live  <= 1'b0;
      end else begin
         state <= state_nxt;
         live  <= 1'b1;
      end
   end

   // Built from in_valid/live rather than in_ready to keep the ready path acyclic.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_FILL: begin
            in_ready = live;
            if (in_valid && live && in_last && at_last) state_nxt = ST_FULL;
         end
         ST_FULL: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_FILL;
         end
         default: state_nxt = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         err_len  <= 1'b0;
         out_step <= '0;
         for (int i = 0; i < SIZE; i++) slot[i] <= '0;
      end else begin
         err_len <= frame_bad;
         if (accept) begin
            slot[idx] <= coef_w;
            if (idx == '0) out_step <= in_step;
            // Any frame end, good or bad, rewinds to slot 0.
            idx <= (in_last || at_last) ? '0 : idx + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < SIZE; g++) begin : g_out
      assign out_list[g*WIDTH +: WIDTH] = slot[g];
   end
endmodule

// File: tb/tb_coef_frame_loader.sv
// Self-checking bench for coef_frame_loader: table vectors, hand corner cases and
// random-gap frames against a frame-level reference model.
module tb_coef_frame_loader;
   localparam int WIDTH   = 32;
   localparam int SIZE    = 257;
   localparam int MODULUS = 1543;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [WIDTH-1:0]      in_coef = '0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic                  in_last = 1'b0;
   logic [2:0]            in_step = '0;
   logic [SIZE*WIDTH-1:0] out_list;
   logic [2:0]            out_step;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic                  err_len;

   coef_frame_loader #(.WIDTH(WIDTH), .SIZE(SIZE), .MODULUS(MODULUS)) dut (
      .clk(clk), .rst_n(rst_n), .in_coef(in_coef), .in_valid(in_valid),
      .in_ready(in_ready), .in_last(in_last), .in_step(in_step),
      .out_list(out_list), .out_step(out_step), .out_valid(out_valid),
      .out_ready(out_ready), .err_len(err_len)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [WIDTH-1:0] frame_data [SIZE];
   logic [WIDTH-1:0] exp_slot [SIZE];
   logic [2:0]       exp_step;

   typedef struct {
      int               pos;
      logic [WIDTH-1:0] coef;
      logic [WIDTH-1:0] exp_red;
      logic [WIDTH-1:0] exp_raw;
   } vec_t;
   vec_t tbl [6];

   function automatic logic [WIDTH-1:0] ref_store(input logic [WIDTH-1:0] c);
`ifdef COEF_FRAME_LOADER_REDUCE_EN
      return (c >= WIDTH'(MODULUS)) ? c - WIDTH'(MODULUS) : c;
`else
      return c;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_expect(input logic [2:0] step0);
      for (int i = 0; i < SIZE; i++) exp_slot[i] = ref_store(frame_data[i]);
      exp_step = step0;
   endtask

   task automatic check_frame(input string name);
      int bad;
      bad = -1;
      n_chk++;
      for (int i = 0; i < SIZE; i++)
         if (bad < 0 && out_list[i*WIDTH +: WIDTH] !== exp_slot[i]) bad = i;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: slot %0d got %0d expected %0d", name, bad,
                  out_list[bad*WIDTH +: WIDTH], exp_slot[bad]);
      end else if (out_step !== exp_step) begin
         n_fail++;
         $display("FAIL %s: out_step got %0d expected %0d", name, out_step, exp_step);
      end
   endtask

   task automatic drive_beat(input logic [WIDTH-1:0] c, input logic l, input logic [2:0] s);
      int w;
      in_coef = c; in_last = l; in_step = s; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (w >= 50) chk("beat wait timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic last_at_end, input logic [2:0] step0,
                             input int idle_pct);
      for (int i = 0; i < n; i++) begin
         int idles;
         idles = 0;
         while (idle_pct > 0 && $urandom_range(99) < idle_pct && idles < 4) begin
            in_valid = 1'b0; in_coef = $urandom; in_step = 3'($urandom);
            @(posedge clk); #1;
            idles++;
         end
         drive_beat(frame_data[i], (i == n - 1) && last_at_end,
                    (i == 0) ? step0 : 3'($urandom));
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < SIZE; i++) frame_data[i] = $urandom;
   endtask

   task automatic release_frame(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({name, " out_valid after handshake"}, out_valid, 0);
      chk({name, " in_ready after handshake"}, in_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]            st;
      logic [SIZE*WIDTH-1:0] held;

      tbl[0] = '{0,   32'd1542,       32'd1542,       32'd1542};
      tbl[1] = '{50,  32'd1543,       32'd0,          32'd1543};
      tbl[2] = '{100, 32'd3000,       32'd1457,       32'd3000};
      tbl[3] = '{150, 32'd0,          32'd0,          32'd0};
      tbl[4] = '{200, 32'd1544,       32'd1,          32'd1544};
      tbl[5] = '{256, 32'hFFFF_FFFF,  32'hFFFF_F9F8,  32'hFFFF_FFFF};

      // reset state
      #3;
      chk("reset in_ready", in_ready, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset err_len", err_len, 0);
      chk("reset out_step", out_step, 0);
      chk("reset out_list zero", |out_list, 0);
      #19 rst_n = 1'b1;
      chk("in_ready before first edge", in_ready, 0);
      @(posedge clk); #1;
      chk("in_ready after release", in_ready, 1);

      // ramp frame, back-to-back, out_ready high
      for (int i = 0; i < SIZE; i++) frame_data[i] = WIDTH'(i);
      set_expect(3'd5);
      out_ready = 1'b1;
      send_frame(SIZE, 1'b1, 3'd5, 0);
      chk("ramp out_valid", out_valid, 1);
      chk("ramp in_ready low", in_ready, 0);
      check_frame("ramp frame");
      release_frame("ramp");

      // table vectors for stored-value mapping at boundary slots
      fill_random();
      for (int k = 0; k < 6; k++) frame_data[tbl[k].pos] = tbl[k].coef;
      st = 3'd2;
      set_expect(st);
      send_frame(SIZE, 1'b1, st, 0);
      chk("table out_valid", out_valid, 1);
      for (int k = 0; k < 6; k++) begin
`ifdef COEF_FRAME_LOADER_REDUCE_EN
         chk($sformatf("table slot %0d", tbl[k].pos),
             out_list[tbl[k].pos*WIDTH +: WIDTH], tbl[k].exp_red);
`else
         chk($sformatf("table slot %0d", tbl[k].pos),
             out_list[tbl[k].pos*WIDTH +: WIDTH], tbl[k].exp_raw);
`endif
      end
      check_frame("table frame");
      release_frame("table");

      // backpressure: hold in FULL for 20 cycles with in_valid driven
      fill_random();
      st = 3'd7;
      set_expect(st);
      out_ready = 1'b0;
      send_frame(SIZE, 1'b1, st, 0);
      held = out_list;
      for (int c = 0; c < 20; c++) begin
         in_valid = 1'b1; in_coef = $urandom; in_last = 1'($urandom); in_step = 3'($urandom);
         @(posedge clk); #1;
         chk("hold out_valid", out_valid, 1);
         chk("hold in_ready", in_ready, 0);
         chk("hold out_list stable", (out_list === held) ? 1 : 0, 1);
      end
      in_valid = 1'b0; in_last = 1'b0;
      check_frame("hold frame");
      release_frame("hold");

      // short frame: in_last on beat 99
      fill_random();
      send_frame(100, 1'b1, 3'd1, 0);
      chk("short err_len", err_len, 1);
      chk("short out_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("short err_len one cycle", err_len, 0);
      chk("short out_valid stays low", out_valid, 0);
      fill_random();
      set_expect(3'd4);
      send_frame(SIZE, 1'b1, 3'd4, 0);
      chk("after short out_valid", out_valid, 1);
      check_frame("after short frame");
      release_frame("after short");

      // long frame: no in_last on beat 256
      fill_random();
      send_frame(SIZE, 1'b0, 3'd6, 0);
      chk("long err_len", err_len, 1);
      chk("long out_valid", out_valid, 0);
      fill_random();
      set_expect(3'd3);
      send_frame(SIZE, 1'b1, 3'd3, 0);
      chk("after long out_valid", out_valid, 1);
      check_frame("after long frame");
      release_frame("after long");

      // asynchronous reset at beat 150
      fill_random();
      for (int i = 0; i < 150; i++) drive_beat(frame_data[i], 1'b0, (i == 0) ? 3'd6 : 3'd1);
      in_valid = 1'b1; in_coef = frame_data[150];
      #3 rst_n = 1'b0;
      #1;
      chk("midrst in_ready", in_ready, 0);
      chk("midrst out_valid", out_valid, 0);
      chk("midrst out_step", out_step, 0);
      chk("midrst out_list zero", |out_list, 0);
      chk("midrst err_len", err_len, 0);
      in_valid = 1'b0;
      #21 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst in_ready after release", in_ready, 1);
      chk("midrst no stale out_valid", out_valid, 0);
      fill_random();
      set_expect(3'd0);
      send_frame(SIZE, 1'b1, 3'd0, 0);
      chk("after reset out_valid", out_valid, 1);
      check_frame("after reset frame");
      release_frame("after reset");

      // random gaps and random downstream stalls over 10 frames
      for (int f = 0; f < 10; f++) begin
         int waitc;
         fill_random();
         st = 3'($urandom);
         set_expect(st);
         out_ready = 1'($urandom);
         send_frame(SIZE, 1'b1, st, 30);
         chk($sformatf("rand frame %0d out_valid", f), out_valid, 1);
         check_frame($sformatf("rand frame %0d", f));
         out_ready = 1'b0;
         waitc = $urandom_range(3);
         for (int c = 0; c < waitc; c++) begin
            @(posedge clk); #1;
         end
         check_frame($sformatf("rand frame %0d held", f));
         release_frame($sformatf("rand frame %0d", f));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/coef_frame_loader.md
COEF_FRAME_LOADER -- requirements
Module: coef_frame_loader

Interface
REQ-001 Parameter WIDTH, default 32, coefficient bit width.
REQ-002 Parameter SIZE, default 257, coefficients per frame (transform length).
REQ-003 Parameter MODULUS, default 1543, prime modulus q; used only when reduction is compiled in.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_coef  input  WIDTH  streamed coefficient, index order 0..SIZE-1.
REQ-007 in_valid  input  1  in_coef/in_last/in_step valid.
REQ-008 in_ready  output  1  loader accepts a beat this cycle.
REQ-009 in_last  input  1  marks final beat of a frame.
REQ-010 in_step  input  3  per-frame shift amount; sampled on beat 0 only.
REQ-011 out_list  output  SIZE*WIDTH  assembled frame; coefficient i at bits [i*WIDTH +: WIDTH].
REQ-012 out_step  output  3  step captured with the frame.
REQ-013 out_valid  output  1  out_list/out_step hold a complete frame.
REQ-014 out_ready  input  1  downstream bit-reversal stage consumes the frame.
REQ-015 err_len  output  1  one-cycle pulse on framing error.

Function
REQ-016 Beat accepted iff in_valid && in_ready on a rising edge.
REQ-017 FSM states: FILL, FULL. FILL: in_ready=1, out_valid=0. FULL: in_ready=0, out_valid=1.
REQ-018 Index counter (ceil(log2(SIZE)) bits) addresses the write slot; each accepted beat writes slot idx and increments idx.
REQ-019 Beat at idx 0 captures in_step into the out_step register.
REQ-020 Accepted beat with idx==SIZE-1 and in_last=1: transition FILL->FULL; out_valid high the next cycle; idx returns to 0.
REQ-021 Accepted beat with in_last=1 and idx!=SIZE-1 (short frame), or idx==SIZE-1 and in_last=0 (long frame): frame discarded, idx returns to 0, err_len pulses high the next cycle, state stays FILL.
REQ-022 FULL: out_list/out_step stable until handshake; out_valid && out_ready -> FILL next cycle; in_ready rises the cycle after handshake (no same-cycle bypass).
REQ-023 Slots are not cleared between frames; out_list is valid only while out_valid=1.
REQ-024 Minimum frame period SIZE+1 cycles with out_ready tied high.

Reset
REQ-025 rst_n low asynchronously forces: state FILL, idx 0, out_valid 0, err_len 0, out_step 0, out_list all zero.
REQ-026 in_ready SHALL be 0 while rst_n is low and 1 from the first edge after release.
REQ-027 Reset mid-frame or in FULL discards the partial/held frame; no output handshake follows.

Configuration
REQ-028 Macro COEF_FRAME_LOADER_REDUCE_EN defined: each accepted in_coef >= MODULUS is stored as in_coef-MODULUS (single conditional subtraction, no added latency).
REQ-029 Macro undefined: in_coef stored unmodified; MODULUS unused; no subtractor synthesized.

Structure
REQ-030 Shared package ntt_pkg holds default WIDTH, SIZE, MODULUS, the step width (3) and the FSM state encoding.
REQ-031 One sub-module, coef_cond_sub (combinational conditional subtract), instantiated only under COEF_FRAME_LOADER_REDUCE_EN.

Verification
REQ-032 Stream 0..256 back-to-back, in_step=5, in_last on beat 256, out_ready=1 -> out_valid one cycle after beat 256, slot i == i, out_step==5, in_ready low one cycle.
REQ-033 Hold out_ready=0 for 20 cycles after full -> out_valid stays 1, out_list stable, in_ready=0 throughout, in_valid ignored.
REQ-034 in_last on beat 99 -> err_len pulse next cycle, no out_valid; next full 257-beat frame delivered correctly.
REQ-035 rst_n low at beat 150 (asynchronous, mid-cycle) -> outputs zero immediately; fresh 257-beat frame after release produces correct output.
REQ-036 REDUCE_EN defined, coefficients 1542, 1543, 3000 -> stored 1542, 0, 1457; undefined -> stored unchanged.
REQ-037 Random in_valid gaps (~30% idle) over 10 frames -> every frame matches the scoreboard, in_step captured from beat 0 only.
